// File: rtl/nios_accelerometer_led_sequencer.sv
// Avalon-MM LED pattern sequencer: static, blink, scroll and bounce patterns stepped by a prescaler.
// Optional PWM brightness control is compiled in with the LED_SEQ_PWM_EN macro.
module nios_accelerometer_led_sequencer #(
  parameter int PRESCALE_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [9:0]  out_port
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_SCROLL = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  state_t                state_r;
  state_t                state_s;
  logic [9:0]            data_r;
  logic [9:0]            data_nx_s;
  logic                  en_r;
  logic [1:0]            mode_r;
  logic [1:0]            mode_nx_s;
  logic [PRESCALE_W-1:0] period_r;
  logic [PRESCALE_W-1:0] presc_r;
  logic [PRESCALE_W-1:0] presc_s;
  logic [PRESCALE_W-1:0] step_target_s;
  logic                  period_one_s;
  logic [7:0]            step_cnt_r;
  logic [7:0]            step_cnt_s;
  logic [9:0]            disp_r;
  logic [9:0]            disp_s;
  logic                  aux_r;
  logic                  aux_s;
  logic                  wr_s;
  logic                  wr_data_s;
  logic                  wr_ctrl_s;
  logic                  wr_period_s;
  logic                  reseed_s;
  logic [10:0]           stepped_s;
  logic [31:0]           period_ext_s;
  logic [7:0]            duty_rd_s;
  logic                  unused_wdata_s;

  // Pattern on entry or reseed; bounce always restarts from LED 0.
  function automatic logic [9:0] seed_pattern(input logic [1:0] mode, input logic [9:0] data);
    logic [9:0] r;
    if (mode == MODE_BOUNCE) begin
      r = 10'h001;
    end else begin
      r = data;
    end
    return r;
  endfunction

  // One step of the pattern. aux is the blink phase (1 = showing DATA) or the bounce direction (1 = up).
  function automatic logic [10:0] step_pattern(input logic [1:0] mode, input logic [9:0] data,
                                               input logic [9:0] disp, input logic aux);
    logic [10:0] r;
    r = {aux, disp};
    case (mode)
      MODE_STATIC: r = {aux, data};
      MODE_BLINK:  r = aux ? {1'b0, 10'h000} : {1'b1, data};
      MODE_SCROLL: r = {aux, disp[8:0], disp[9]};
      MODE_BOUNCE: begin
        if (disp == 10'h000) begin
          r = {1'b1, 10'h001};
        end else if (aux) begin
          r = disp[9] ? {1'b0, 1'b0, disp[9:1]} : {1'b1, disp[8:0], 1'b0};
        end else begin
          r = disp[0] ? {1'b1, disp[8:0], 1'b0} : {1'b0, 1'b0, disp[9:1]};
        end
      end
      default: r = {aux, disp};
    endcase
    return r;
  endfunction

  assign wr_s        = chipselect & ~write_n;
  assign wr_data_s   = wr_s && (address == 2'd0);
  assign wr_ctrl_s   = wr_s && (address == 2'd1);
  assign wr_period_s = wr_s && (address == 2'd2);
  assign reseed_s    = wr_data_s | wr_ctrl_s;

  // Register writes land first, so seeds taken this edge use the values being written.
  assign data_nx_s = wr_data_s ? writedata[9:0] : data_r;
  assign mode_nx_s = wr_ctrl_s ? writedata[2:1] : mode_r;

  // The STEP cycle is part of the period, so RUN hands over one count early.
  assign period_one_s  = (period_r <= PRESCALE_W'(1));
  assign step_target_s = (period_r <= PRESCALE_W'(2)) ? {PRESCALE_W{1'b0}} : (period_r - PRESCALE_W'(2));
  assign stepped_s     = step_pattern(mode_r, data_r, disp_r, aux_r);

  assign unused_wdata_s = ^writedata;

  // Next-state and datapath for the sequencer FSM.
  always_comb begin
    state_s    = state_r;
    presc_s    = presc_r;
    step_cnt_s = step_cnt_r;
    disp_s     = disp_r;
    aux_s      = aux_r;
    case (state_r)
      IDLE: begin
        if (en_r) begin
          state_s = RUN;
          presc_s = {PRESCALE_W{1'b0}};
          disp_s  = seed_pattern(mode_nx_s, data_nx_s);
          aux_s   = 1'b1;
        end else begin
          disp_s  = data_nx_s;
        end
      end
      RUN: begin
        if (!en_r) begin
          state_s = IDLE;
          presc_s = {PRESCALE_W{1'b0}};
          disp_s  = data_nx_s;
        end else begin
          if (wr_ctrl_s) begin
            presc_s = {PRESCALE_W{1'b0}};
          end else if (presc_r >= step_target_s) begin
            presc_s = presc_r + PRESCALE_W'(1);
            state_s = STEP;
          end else begin
            presc_s = presc_r + PRESCALE_W'(1);
          end
          if (reseed_s) begin
            disp_s = seed_pattern(mode_nx_s, data_nx_s);
            aux_s  = 1'b1;
          end else begin
            disp_s = disp_r;
          end
        end
      end
      STEP: begin
        if (!en_r) begin
          state_s = IDLE;
          presc_s = {PRESCALE_W{1'b0}};
          disp_s  = data_nx_s;
        end else begin
          presc_s    = {PRESCALE_W{1'b0}};
          step_cnt_s = step_cnt_r + 8'd1;
          state_s    = period_one_s ? STEP : RUN;
          if (reseed_s) begin
            disp_s = seed_pattern(mode_nx_s, data_nx_s);
            aux_s  = 1'b1;
          end else begin
            disp_s = stepped_s[9:0];
            aux_s  = stepped_s[10];
          end
        end
      end
      default: begin
        state_s = IDLE;
        presc_s = {PRESCALE_W{1'b0}};
        disp_s  = data_nx_s;
      end
    endcase
  end

  // Register file and sequencer state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r     <= 10'h000;
      en_r       <= 1'b0;
      mode_r     <= MODE_STATIC;
      period_r   <= PRESCALE_W'(1);
      presc_r    <= {PRESCALE_W{1'b0}};
      step_cnt_r <= 8'h00;
      state_r    <= IDLE;
      disp_r     <= 10'h000;
      aux_r      <= 1'b1;
    end else begin
      data_r <= data_nx_s;
      if (wr_ctrl_s) begin
        en_r   <= writedata[0];
        mode_r <= writedata[2:1];
      end
      if (wr_period_s) begin
        period_r <= writedata[PRESCALE_W-1:0];
      end
      presc_r    <= presc_s;
      step_cnt_r <= step_cnt_s;
      state_r    <= state_s;
      disp_r     <= disp_s;
      aux_r      <= aux_s;
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [7:0] pwm_cnt_r;
  logic [7:0] duty_r;

  // Free-running PWM counter and DUTY register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_r <= 8'h00;
      duty_r    <= 8'hFF;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 8'd1;
      if (wr_s && (address == 2'd3)) begin
        duty_r <= writedata[7:0];
      end
    end
  end

  assign duty_rd_s = duty_r;
  assign out_port  = disp_r & {10{pwm_cnt_r < duty_r}};
`else
  assign duty_rd_s = 8'h00;
  assign out_port  = disp_r;
`endif

  // PERIOD zero-extended to the bus width.
  always_comb begin
    period_ext_s = 32'h0000_0000;
    period_ext_s[PRESCALE_W-1:0] = period_r;
  end

  // Read mux.
  always_comb begin
    readdata = 32'h0000_0000;
    case (address)
      2'd0:    readdata = {22'h000000, data_r};
      2'd1:    readdata = {29'h00000000, mode_r, en_r};
      2'd2:    readdata = period_ext_s;
      2'd3:    readdata = {4'h0, duty_rd_s, step_cnt_r, state_r, disp_r};
      default: readdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: doc/nios_accelerometer_led_sequencer.md
NIOS_ACCELEROMETER_LED_SEQUENCER -- requirements
Module: nios_accelerometer_led_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 24, meaning the width of the step-period counter and PERIOD register.
REQ-002 SHALL have port clk  input  1  system clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port address  input  2  Avalon-MM register select.
REQ-005 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-006 SHALL have port write_n  input  1  Avalon-MM write strobe, active low.
REQ-007 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-008 SHALL have port readdata  output  32  Avalon-MM read data, combinational from address, zero-extended.
REQ-009 SHALL have port out_port  output  10  LED drive, bit n = LEDR[n].

Function
REQ-010 SHALL decode a write as chipselect=1 and write_n=0, committed on that clk edge.
REQ-011 SHALL map the register at address 0 as DATA[9:0], the base pattern, read/write.
REQ-012 SHALL map the register at address 1 as CTRL: bit0 EN, bits[2:1] MODE (00 static, 01 blink, 10 scroll, 11 bounce), read/write; unused bits SHALL read 0.
REQ-013 SHALL map the register at address 2 as PERIOD[PRESCALE_W-1:0], clk cycles per step, read/write; the value 0 SHALL behave as 1.
REQ-014 SHALL map address 3 as STATUS (read-only without PWM): [9:0] current display, [11:10] FSM state, [19:12] step count mod 256.
REQ-015 SHALL run an FSM with states IDLE=0, RUN=1, STEP=2.
REQ-016 SHALL go IDLE->RUN on the edge after EN becomes 1, clear the prescaler, and load the display per REQ-020.
REQ-017 SHALL, in RUN, increment the prescaler each cycle and go to STEP when prescaler = max(PERIOD,1)-1.
REQ-018 SHALL, in STEP (exactly one cycle), update the display per MODE, clear the prescaler, increment the step count, and return to RUN.
REQ-019 SHALL go from any state to IDLE on the edge after EN becomes 0; in IDLE, display = DATA and the step count SHALL hold.
REQ-020 SHALL use these step rules: static, display = DATA; blink, display alternates DATA, 0, DATA, ...; scroll, display rotates left by 1 with bit9->bit0, seeded from DATA on entry; bounce, a single lit LED moves 0->9->0 with no repeat at the ends, starting at bit0 with direction up.
REQ-021 SHALL, on a write to DATA while in RUN, reseed the display from the new DATA on the next edge without resetting the prescaler.
REQ-022 SHALL, on a write to MODE while in RUN, reseed as on entry and clear the prescaler.
REQ-023 SHALL, on a write to PERIOD below the current prescaler value, cause STEP on the next cycle and not wrap.
REQ-024 SHALL, when a register write and a STEP coincide, apply the register write first; the reseed overrides the step update.
REQ-025 SHALL drive out_port from the display register with no additional latency.

Reset
REQ-026 SHALL, while reset=1, asynchronously set DATA=0, CTRL=0, PERIOD=1, prescaler=0, step count=0, state=IDLE, display=0, out_port=0, and duty=0xFF when PWM is compiled in.
REQ-027 SHALL, on reset assertion mid-step, lose all progress; after release the block starts in IDLE.

Configuration
REQ-028 SHALL, with macro LED_SEQ_PWM_EN defined, add an 8-bit free-running PWM counter and an 8-bit DUTY register written via address 3 writedata[7:0] and read at STATUS[27:20].
REQ-029 SHALL, with LED_SEQ_PWM_EN defined, drive out_port = display AND {10{pwm_cnt < DUTY}}, where DUTY=0xFF gives 255/256 on-time and DUTY=0 gives off.
REQ-030 SHALL, without LED_SEQ_PWM_EN, ignore address-3 writes, read STATUS[27:20] as 0, and drive out_port = display.

Verification
REQ-031 SHALL verify reset: assert reset mid-RUN, then check out_port=0, readdata@1=0, readdata@2=1, and STATUS[11:10]=0.
REQ-032 SHALL verify scroll: write DATA=0x001, PERIOD=4, CTRL=0x5; out_port SHALL read 0x001, 0x002, 0x004 with each change 4 cycles apart, and 0x200 SHALL be followed by 0x001.
REQ-033 SHALL verify bounce: write PERIOD=0, CTRL=0x7; out_port SHALL step every cycle through 0x001 up to 0x200, then 0x100, with 18 steps per cycle and STATUS[19:12]=18 after 18 steps.
REQ-034 SHALL verify blink and disable: write DATA=0x3FF, PERIOD=2, CTRL=0x3 to get the sequence 0x3FF, 0x000, 0x3FF; writing CTRL=0 SHALL give out_port=0x3FF and state IDLE on the next edge.
REQ-035 SHALL verify the collision case: a DATA=0x0F0 write on the same edge as a STEP SHALL give next display 0x0F0, not the stepped value.
REQ-036 SHALL verify PWM with LED_SEQ_PWM_EN: DUTY=0x40 and static DATA=0x3FF SHALL give out_port=0x3FF for exactly 64 of every 256 cycles; without the macro, out_port SHALL stay constant at 0x3FF.
